cam_pixel_pack: RTL and testbench

CAM_PIXEL_PACK -- requirements
Module: cam_pixel_pack

---
 rtl/cam_pixel_pack.sv | 176 +++++++++++++++++
 tb/tb_cam_pixel_pack.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_pack.sv
// Camera byte-stream to pixel packer: assembles BPP bytes per pixel, optionally
// expands RGB565 to RGB888, and tracks column/line position plus line framing.
module cam_pixel_pack #(
  parameter int BPP       = 2,
  parameter int OUT_W     = 24,
  parameter int CW        = 12,
  parameter int BYTE_SWAP = 0,
  parameter int VS_POL    = 1
) (
  input  logic             tpclk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             de,
  input  logic             vs,
  input  logic             mode,
  output logic             pix_valid,
  output logic [OUT_W-1:0] pix_data,
  output logic [CW-1:0]    pix_x,
  output logic [CW-1:0]    pix_y,
  output logic             sof,
  output logic             line_done,
  output logic [CW-1:0]    line_len,
  output logic             line_err
);

  localparam int             BW     = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int             AW     = 8 * BPP;
  localparam logic [BW-1:0]  B_LAST = BW'(BPP - 1);
  localparam logic [CW-1:0]  C_MAX  = '1;
  localparam logic           VS_LVL = (VS_POL != 0);

  logic            vs_prev_reg;
  logic            mode_lat_reg;
  logic            mode_follow_reg;
  logic [BW-1:0]   bcnt_reg;
  logic [CW-1:0]   cnt_reg;
  logic [CW-1:0]   line_reg;
  logic            sof_arm_reg;

  logic            vs_act;
  logic            vs_edge;
  logic            mode_eff;
  logic            byte_last;
  logic            pix_done;
  logic            line_open;
  logic [AW-1:0]   asm_word;
  logic [OUT_W-1:0] pix_word;

  assign vs_act    = (vs == VS_LVL);
  assign vs_edge   = vs_act & ~vs_prev_reg;
  // Until the first clock after reset the frame mode tracks the input directly.
  assign mode_eff  = mode_follow_reg ? mode : mode_lat_reg;
  assign byte_last = (bcnt_reg == B_LAST);
  assign pix_done  = de & byte_last;
  assign line_open = (cnt_reg != '0) || (bcnt_reg != '0);

  // Byte assembly: asm_word is the full pixel including the byte on data_in.
  generate
    if (BPP == 1) begin : g_asm_single
      assign asm_word = data_in;
    end else begin : g_asm_multi
      logic [AW-9:0] asm_reg;

      if (BYTE_SWAP != 0) begin : g_lsb_first
        assign asm_word = {data_in, asm_reg};
      end else begin : g_msb_first
        assign asm_word = {asm_reg, data_in};
      end

      always_ff @(posedge tpclk or posedge rst) begin
        if (rst) begin
          asm_reg <= '0;
        end else if (vs_edge) begin
          asm_reg <= '0;
        end else if (de) begin
          asm_reg <= (BYTE_SWAP != 0) ? asm_word[AW-1:8] : asm_word[AW-9:0];
        end
      end
    end
  endgenerate

  generate
    if (BPP == 2) begin : g_rgb
      logic [23:0] rgb888;
      assign rgb888 = {asm_word[15:11], asm_word[15:13],
                       asm_word[10:5],  asm_word[10:9],
                       asm_word[4:0],   asm_word[4:2]};
      assign pix_word = mode_eff ? OUT_W'(rgb888) : OUT_W'(asm_word);
    end else begin : g_raw
      assign pix_word = OUT_W'(asm_word);
    end
  endgenerate

  // Frame sync edge detect and per-frame mode latch.
  always_ff @(posedge tpclk or posedge rst) begin
    if (rst) begin
      vs_prev_reg     <= 1'b0;
      mode_lat_reg    <= 1'b0;
      mode_follow_reg <= 1'b1;
    end else begin
      vs_prev_reg     <= vs_act;
      mode_follow_reg <= 1'b0;
      if (vs_edge || mode_follow_reg) begin
        mode_lat_reg <= mode;
      end
    end
  end

  // Byte, pixel and line counters; a vs edge overrides any line activity.
  always_ff @(posedge tpclk or posedge rst) begin
    if (rst) begin
      bcnt_reg    <= '0;
      cnt_reg     <= '0;
      line_reg    <= '0;
      sof_arm_reg <= 1'b1;
    end else if (vs_edge) begin
      bcnt_reg    <= '0;
      cnt_reg     <= '0;
      line_reg    <= '0;
      sof_arm_reg <= 1'b1;
    end else if (de) begin
      bcnt_reg <= byte_last ? '0 : bcnt_reg + BW'(1);
      if (pix_done) begin
        sof_arm_reg <= 1'b0;
        if (cnt_reg != C_MAX) begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end else begin
      bcnt_reg <= '0;
      cnt_reg  <= '0;
      if ((cnt_reg != '0) && (line_reg != C_MAX)) begin
        line_reg <= line_reg + CW'(1);
      end
    end
  end

  // Pixel output: the completing pixel is emitted even on a vs edge cycle.
  always_ff @(posedge tpclk or posedge rst) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      sof       <= 1'b0;
      if (pix_done) begin
        pix_valid <= 1'b1;
        pix_data  <= pix_word;
        pix_x     <= cnt_reg;
        pix_y     <= line_reg;
        sof       <= sof_arm_reg;
      end
    end
  end

  // Line end reporting on the first cycle with de low after an active line.
  always_ff @(posedge tpclk or posedge rst) begin
    if (rst) begin
      line_done <= 1'b0;
      line_len  <= '0;
      line_err  <= 1'b0;
    end else begin
      line_done <= 1'b0;
      line_err  <= 1'b0;
      if (!vs_edge && !de && line_open) begin
        line_done <= 1'b1;
        line_len  <= cnt_reg;
        line_err  <= (bcnt_reg != '0);
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_pack.sv
// Scoreboard bench for cam_pixel_pack: a reference model queues expected pixels
// and line events as bytes are driven; a negedge monitor pops and compares them.
module tb_cam_pixel_pack;

  logic tpclk = 1'b0;
  always #5 tpclk = ~tpclk;

  logic rst;

  logic [7:0]  a_data;
  logic        a_de, a_vs, a_mode;
  logic        a_pix_valid, a_sof, a_line_done, a_line_err;
  logic [23:0] a_pix_data;
  logic [11:0] a_pix_x, a_pix_y, a_line_len;

  logic [7:0]  b_data;
  logic        b_de, b_vs, b_mode;
  logic        b_pix_valid, b_sof, b_line_done, b_line_err;
  logic [23:0] b_pix_data;
  logic [11:0] b_pix_x, b_pix_y, b_line_len;

  cam_pixel_pack #(.BPP(2)) dut_a (
    .tpclk(tpclk), .rst(rst), .data_in(a_data), .de(a_de), .vs(a_vs), .mode(a_mode),
    .pix_valid(a_pix_valid), .pix_data(a_pix_data), .pix_x(a_pix_x), .pix_y(a_pix_y),
    .sof(a_sof), .line_done(a_line_done), .line_len(a_line_len), .line_err(a_line_err)
  );

  cam_pixel_pack #(.BPP(3), .BYTE_SWAP(1)) dut_b (
    .tpclk(tpclk), .rst(rst), .data_in(b_data), .de(b_de), .vs(b_vs), .mode(b_mode),
    .pix_valid(b_pix_valid), .pix_data(b_pix_data), .pix_x(b_pix_x), .pix_y(b_pix_y),
    .sof(b_sof), .line_done(b_line_done), .line_len(b_line_len), .line_err(b_line_err)
  );

  typedef struct {
    logic [23:0] data;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    int          due;
  } pix_t;

  typedef struct {
    logic [11:0] len;
    logic        err;
    int          due;
  } line_t;

  pix_t  exp_pix[$];
  line_t exp_line[$];
  pix_t  mon_pix;
  line_t mon_line;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge tpclk) cyc <= cyc + 1;

  // Reference model state for dut_a
  logic [11:0] m_x, m_y;
  logic        m_sof_arm, m_mode, m_vs_prev;
  int          m_bcnt;
  logic [7:0]  m_hi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] rgb_of(input logic [15:0] w);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = w[15:11];
    g = w[10:5];
    b = w[4:0];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

  task automatic model_reset();
    m_x       = '0;
    m_y       = '0;
    m_sof_arm = 1'b1;
    m_bcnt    = 0;
    m_vs_prev = 1'b0;
    m_mode    = a_mode;
  endtask

  // One clock of stimulus for dut_a, updating the model and scoreboard first.
  task automatic a_step(input logic de, input logic [7:0] b, input logic vs);
    pix_t        e;
    line_t       l;
    logic        edge_now;
    logic [15:0] w;
    edge_now = vs && !m_vs_prev;
    if (de) begin
      if (m_bcnt == 0) begin
        m_hi   = b;
        m_bcnt = 1;
      end else begin
        w      = {m_hi, b};
        e.data = m_mode ? rgb_of(w) : {8'h00, w};
        e.x    = m_x;
        e.y    = m_y;
        e.sof  = m_sof_arm;
        e.due  = cyc + 1;
        exp_pix.push_back(e);
        if (m_x != 12'hFFF) m_x++;
        m_sof_arm = 1'b0;
        m_bcnt    = 0;
      end
    end else if (!edge_now && (m_x != 0 || m_bcnt != 0)) begin
      l.len = m_x;
      l.err = (m_bcnt != 0);
      l.due = cyc + 1;
      exp_line.push_back(l);
      if (m_x != 0 && m_y != 12'hFFF) m_y++;
    end
    if (!de) begin
      m_x    = '0;
      m_bcnt = 0;
    end
    if (edge_now) begin
      m_x       = '0;
      m_y       = '0;
      m_sof_arm = 1'b1;
      m_bcnt    = 0;
      m_mode    = a_mode;
    end
    m_vs_prev = vs;
    a_de   = de;
    a_data = b;
    a_vs   = vs;
    @(posedge tpclk);
    #1;
  endtask

  task automatic a_idle(input int n);
    for (int i = 0; i < n; i++) a_step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic a_frame();
    a_step(1'b0, 8'h00, 1'b1);
    a_step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic b_step(input logic de, input logic [7:0] b, input logic vs);
    b_de   = de;
    b_data = b;
    b_vs   = vs;
    @(posedge tpclk);
    #1;
  endtask

  always @(negedge tpclk) begin
    if (!rst) begin
      if (a_pix_valid) begin
        if (exp_pix.size() == 0) begin
          check("a_unexpected_pix", 32'(a_pix_valid), 32'd0);
        end else begin
          mon_pix = exp_pix.pop_front();
          $display("pix  cyc=%0d data=%06h x=%0d y=%0d sof=%0b", cyc, a_pix_data, a_pix_x, a_pix_y, a_sof);
          check("a_pix_data", 32'(a_pix_data), 32'(mon_pix.data));
          check("a_pix_x", 32'(a_pix_x), 32'(mon_pix.x));
          check("a_pix_y", 32'(a_pix_y), 32'(mon_pix.y));
          check("a_sof", 32'(a_sof), 32'(mon_pix.sof));
          check("a_pix_cycle", cyc, mon_pix.due);
        end
      end
      if (a_sof && !a_pix_valid) check("a_sof_alone", 32'(a_sof), 32'd0);
      if (a_line_done || a_line_err) begin
        if (exp_line.size() == 0) begin
          check("a_unexpected_line", 32'(a_line_done | a_line_err), 32'd0);
        end else begin
          mon_line = exp_line.pop_front();
          $display("line cyc=%0d len=%0d err=%0b", cyc, a_line_len, a_line_err);
          check("a_line_done", 32'(a_line_done), 32'd1);
          check("a_line_len", 32'(a_line_len), 32'(mon_line.len));
          check("a_line_err", 32'(a_line_err), 32'(mon_line.err));
          check("a_line_cycle", cyc, mon_line.due);
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    a_data = '0; a_de = 1'b0; a_vs = 1'b0; a_mode = 1'b0;
    b_data = '0; b_de = 1'b0; b_vs = 1'b0; b_mode = 1'b0;
    repeat (3) @(posedge tpclk);
    #1;
    check("rst_pix_valid", 32'(a_pix_valid), 32'd0);
    check("rst_pix_data", 32'(a_pix_data), 32'd0);
    check("rst_sof", 32'(a_sof), 32'd0);
    check("rst_line_done", 32'(a_line_done), 32'd0);
    check("rst_line_len", 32'(a_line_len), 32'd0);
    check("rst_b_pix_valid", 32'(b_pix_valid), 32'd0);
    rst = 1'b0;
    model_reset();
    a_idle(2);

    // Raw BPP=2 line: 0x001234 then 0x005678, sof on the first only
    a_frame();
    a_step(1'b1, 8'h12, 1'b0);
    a_step(1'b1, 8'h34, 1'b0);
    a_step(1'b1, 8'h56, 1'b0);
    a_step(1'b1, 8'h78, 1'b0);
    a_idle(3);

    // RGB565 expansion: F81F -> FF00FF, 07E0 -> 00FF00
    a_mode = 1'b1;
    a_frame();
    a_step(1'b1, 8'hF8, 1'b0);
    a_step(1'b1, 8'h1F, 1'b0);
    a_step(1'b1, 8'h07, 1'b0);
    a_step(1'b1, 8'hE0, 1'b0);
    a_idle(3);

    // Five-byte line: two pixels, partial discarded with line_err
    a_step(1'b1, 8'h10, 1'b0);
    a_step(1'b1, 8'h20, 1'b0);
    a_step(1'b1, 8'h30, 1'b0);
    a_step(1'b1, 8'h40, 1'b0);
    a_step(1'b1, 8'h50, 1'b0);
    a_idle(3);

    // vs edge on a completing byte: pixel emitted, line aborted silently
    a_step(1'b1, 8'h01, 1'b0);
    a_step(1'b1, 8'h02, 1'b0);
    a_step(1'b1, 8'h03, 1'b0);
    a_step(1'b1, 8'h04, 1'b1);
    a_idle(3);
    a_step(1'b1, 8'hAA, 1'b0);
    a_step(1'b1, 8'hBB, 1'b0);
    a_step(1'b1, 8'hCC, 1'b0);
    a_step(1'b1, 8'hDD, 1'b0);
    a_idle(3);

    // Asynchronous reset after the first byte of a pixel
    a_step(1'b1, 8'h5A, 1'b0);
    rst  = 1'b1;
    a_de = 1'b0;
    #1;
    check("arst_pix_valid", 32'(a_pix_valid), 32'd0);
    check("arst_pix_data", 32'(a_pix_data), 32'd0);
    check("arst_pix_x", 32'(a_pix_x), 32'd0);
    check("arst_line_len", 32'(a_line_len), 32'd0);
    check("arst_line_done", 32'(a_line_done), 32'd0);
    repeat (2) @(posedge tpclk);
    #1;
    rst = 1'b0;
    model_reset();
    a_idle(4);
    a_step(1'b1, 8'h12, 1'b0);
    a_step(1'b1, 8'h34, 1'b0);
    a_step(1'b1, 8'h56, 1'b0);
    a_step(1'b1, 8'h78, 1'b0);
    a_idle(3);

    // Three 640-pixel lines with a mid-frame mode change, then a new frame
    a_mode = 1'b1;
    a_frame();
    for (int ln = 0; ln < 3; ln++) begin
      if (ln == 1) a_mode = 1'b0;
      for (int p = 0; p < 640; p++) begin
        a_step(1'b1, 8'(p * 3 + ln), 1'b0);
        a_step(1'b1, 8'(p * 5 + 7), 1'b0);
      end
      a_idle(3);
    end
    a_frame();
    for (int p = 0; p < 3; p++) begin
      a_step(1'b1, 8'(p * 11 + 200), 1'b0);
      a_step(1'b1, 8'(p * 13 + 9), 1'b0);
    end
    a_idle(4);

    // BPP=3 little-endian pixel: 11,22,33 -> 0x332211
    b_step(1'b0, 8'h00, 1'b1);
    b_step(1'b0, 8'h00, 1'b0);
    b_step(1'b1, 8'h11, 1'b0);
    b_step(1'b1, 8'h22, 1'b0);
    b_step(1'b1, 8'h33, 1'b0);
    $display("b pix data=%06h x=%0d sof=%0b", b_pix_data, b_pix_x, b_sof);
    check("b_pix_valid", 32'(b_pix_valid), 32'd1);
    check("b_pix_data", 32'(b_pix_data), 32'h332211);
    check("b_pix_x", 32'(b_pix_x), 32'd0);
    check("b_sof", 32'(b_sof), 32'd1);
    b_step(1'b0, 8'h00, 1'b0);
    $display("b line len=%0d err=%0b", b_line_len, b_line_err);
    check("b_pix_valid_off", 32'(b_pix_valid), 32'd0);
    check("b_line_done", 32'(b_line_done), 32'd1);
    check("b_line_len", 32'(b_line_len), 32'd1);
    check("b_line_err", 32'(b_line_err), 32'd0);
    b_step(1'b0, 8'h00, 1'b0);
    check("b_line_done_pulse", 32'(b_line_done), 32'd0);

    a_idle(4);
    check("a_pix_queue_left", 32'(exp_pix.size()), 32'd0);
    check("a_line_queue_left", 32'(exp_line.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
